// File: rtl/seq_alu.sv
// Clocked ALU with a start/done handshake, an internal accumulator and an
// iterative shift-add multiplier.
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_result_hi,
  output logic             o_carry,
  output logic             o_zero,
  output logic             o_err,
  output logic [WIDTH-1:0] o_acc
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d, result_hi_q, result_hi_d;
  logic               carry_q, carry_d, zero_q, zero_d, err_q, err_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH:0]     sum, psum;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    err_d       = err_q;
    acc_d       = acc_q;
    sum         = '0;
    psum        = '0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          op_d    = i_op;
          a_d     = i_a;
          b_d     = i_b;
          busy_d  = 1'b1;
          cnt_d   = '0;
          prod_d  = {{WIDTH{1'b0}}, i_b};
          state_d = (i_op == 3'b110) ? MUL : EXEC;
        end
      end
      EXEC: begin
        busy_d      = 1'b0;
        done_d      = 1'b1;
        state_d     = DONE;
        result_hi_d = '0;
        carry_d     = 1'b0;
        err_d       = 1'b0;
        case (op_q)
          3'b000: begin
            sum      = {1'b0, a_q} + {1'b0, b_q};
            result_d = sum[WIDTH-1:0];
            carry_d  = sum[WIDTH];
          end
          3'b001: begin
            sum      = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
            result_d = sum[WIDTH-1:0];
            carry_d  = sum[WIDTH];
          end
          3'b010: result_d = a_q & b_q;
          3'b011: result_d = a_q | b_q;
          3'b100: begin
            sum      = {1'b0, acc_q} + {1'b0, a_q};
            acc_d    = sum[WIDTH-1:0];
            result_d = sum[WIDTH-1:0];
            carry_d  = sum[WIDTH];
          end
          3'b101: begin
            acc_d    = '0;
            result_d = '0;
          end
          default: begin
            result_d = '0;
            err_d    = 1'b1;
          end
        endcase
        zero_d = (result_d == '0);
      end
      MUL: begin
        // Product register holds {partial sum, remaining multiplier bits}
        if (cnt_q != CW'(WIDTH)) begin
          psum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
          prod_d = {psum, prod_q[WIDTH-1:1]};
          cnt_d  = cnt_q + CW'(1);
        end else begin
          result_d    = prod_q[WIDTH-1:0];
          result_hi_d = prod_q[2*WIDTH-1:WIDTH];
          carry_d     = 1'b0;
          err_d       = 1'b0;
          zero_d      = (prod_q == '0);
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
      acc_q       <= acc_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_result    = result_q;
  assign o_result_hi = result_hi_q;
  assign o_carry     = carry_q;
  assign o_zero      = zero_q;
  assign o_err       = err_q;
  assign o_acc       = acc_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomised self-checking bench for seq_alu against an arithmetic model of
// the opcode table and handshake timing.
module tb_seq_alu;

  localparam int WIDTH = 4;
  localparam int M     = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic [2:0]       i_op = '0;
  logic [WIDTH-1:0] i_a = '0;
  logic [WIDTH-1:0] i_b = '0;
  logic             o_busy, o_done, o_carry, o_zero, o_err;
  logic [WIDTH-1:0] o_result, o_result_hi, o_acc;

  int total = 0;
  int bad = 0;
  int expRes = 0, expHi = 0, expCarry = 0, expZero = 0, expErr = 0, expAcc = 0;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_op(i_op), .i_a(i_a), .i_b(i_b),
    .o_busy(o_busy), .o_done(o_done), .o_result(o_result), .o_result_hi(o_result_hi),
    .o_carry(o_carry), .o_zero(o_zero), .o_err(o_err), .o_acc(o_acc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: opcode table evaluated with plain integer arithmetic
  task automatic modelOp(input int op, input int a, input int b);
    int s;
    expHi    = 0;
    expCarry = 0;
    expErr   = 0;
    case (op)
      0: begin s = a + b; expRes = s % M; expCarry = s / M; end
      1: begin expRes = (a - b + M) % M; expCarry = (a >= b) ? 1 : 0; end
      2: expRes = a & b;
      3: expRes = a | b;
      4: begin s = expAcc + a; expAcc = s % M; expRes = expAcc; expCarry = s / M; end
      5: begin expAcc = 0; expRes = 0; end
      6: begin s = a * b; expRes = s % M; expHi = s / M; end
      default: begin expRes = 0; expErr = 1; end
    endcase
    expZero = (expRes == 0 && expHi == 0) ? 1 : 0;
  endtask

  task automatic checkResults(input string when);
    checkOutput({when, " result"}, int'(o_result), expRes);
    checkOutput({when, " result_hi"}, int'(o_result_hi), expHi);
    checkOutput({when, " carry"}, int'(o_carry), expCarry);
    checkOutput({when, " zero"}, int'(o_zero), expZero);
    checkOutput({when, " err"}, int'(o_err), expErr);
    checkOutput({when, " acc"}, int'(o_acc), expAcc);
  endtask

  task automatic applyStimulus(input int op, input int a, input int b, input bit disturb);
    int n;
    int expLat;
    expLat = (op == 6) ? WIDTH + 1 : 1;
    modelOp(op, a, b);
    @(negedge clk);
    i_start = 1'b1;
    i_op    = 3'(op);
    i_a     = WIDTH'(a);
    i_b     = WIDTH'(b);
    @(negedge clk);
    i_start = 1'b0;
    n = 0;
    while (o_done !== 1'b1 && n < 40) begin
      checkOutput("busy while running", int'(o_busy), 1);
      if (disturb) begin
        i_start = 1'($urandom_range(0, 1));
        i_op    = 3'($urandom_range(0, 7));
        i_a     = WIDTH'($urandom_range(0, M - 1));
        i_b     = WIDTH'($urandom_range(0, M - 1));
      end
      @(negedge clk);
      n++;
    end
    checkOutput("done latency", n, expLat);
    checkOutput("busy at done", int'(o_busy), 0);
    checkResults("at done");
    // A start presented while in DONE must be ignored
    i_start = 1'b1;
    i_op    = 3'($urandom_range(0, 7));
    @(negedge clk);
    i_start = 1'b0;
    checkOutput("done pulse width", int'(o_done), 0);
    checkOutput("start in DONE ignored", int'(o_busy), 0);
    checkResults("hold");
  endtask

  initial begin
    #3;
    checkOutput("reset busy", int'(o_busy), 0);
    checkOutput("reset done", int'(o_done), 0);
    checkResults("reset");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0, 9, 8, 1'b0);
    applyStimulus(1, 3, 5, 1'b0);
    applyStimulus(1, 5, 5, 1'b0);
    applyStimulus(6, 15, 15, 1'b1);
    applyStimulus(5, 0, 0, 1'b0);
    applyStimulus(4, 7, 0, 1'b0);
    applyStimulus(0, 2, 3, 1'b0);
    applyStimulus(4, 12, 0, 1'b0);
    applyStimulus(7, 6, 9, 1'b0);
    applyStimulus(0, 4, 4, 1'b0);

    for (int i = 0; i < 80; i++) begin
      applyStimulus($urandom_range(0, 7), $urandom_range(0, M - 1),
                    $urandom_range(0, M - 1), 1'($urandom_range(0, 1)));
    end

    // Abort a multiply partway through with an asynchronous reset
    @(negedge clk);
    i_start = 1'b1;
    i_op    = 3'b110;
    i_a     = WIDTH'(15);
    i_b     = WIDTH'(15);
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expRes = 0; expHi = 0; expCarry = 0; expZero = 0; expErr = 0; expAcc = 0;
    checkOutput("async reset busy", int'(o_busy), 0);
    checkOutput("async reset done", int'(o_done), 0);
    checkResults("async reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("no done in reset", int'(o_done), 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("no done after abort", int'(o_done), 0);
      checkOutput("idle after abort", int'(o_busy), 0);
    end
    checkResults("after abort");
    applyStimulus(0, 1, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
